// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchroniser, clock deglitch filter, 11-bit deframer,
// E0/F0 prefix folding and a FWFT event FIFO. Optional macro: PS2_TYPEMATIC_FILTER_EN.
module ps2_rx_fifo #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 32000,
  parameter int DEPTH       = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       ps2_kbd_clk,
  input  logic       ps2_kbd_data,
  output logic [9:0] ev_data,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic       frame_err,
  output logic       overflow
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam int AW = $clog2(DEPTH);
  localparam logic [FW-1:0] FL_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT_CYC);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_STOP} st_t;

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          fclk_q;
  logic [FW-1:0] fcnt_q;
  logic          fdiff, fe;
  st_t           st_q;
  logic [3:0]    bitcnt_q;
  logic [7:0]    sr_q, code_q;
  logic          par_q, decode_q, frame_err_q;
  logic [TW-1:0] tcnt_q;
  logic          ext_q, rel_q;
  logic          is_ext, is_rel, dec_ev, push_req;
  logic [9:0]    ev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s1_q <= 1'b1; clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1; dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_kbd_clk;  clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_kbd_data; dat_s2_q <= dat_s1_q;
    end
  end

  // fe fires in the cycle whose sample would be the FILTER_LEN-th consecutive low one
  assign fdiff = (clk_s2_q != fclk_q);
  assign fe    = fdiff && fclk_q && (fcnt_q == FL_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fclk_q <= 1'b1;
      fcnt_q <= '0;
    end else if (!fdiff) begin
      fcnt_q <= '0;
    end else if (fcnt_q == FL_LAST) begin
      fclk_q <= ~fclk_q;
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st_q        <= S_IDLE;
      bitcnt_q    <= '0;
      sr_q        <= '0;
      par_q       <= 1'b0;
      code_q      <= '0;
      decode_q    <= 1'b0;
      frame_err_q <= 1'b0;
      tcnt_q      <= '0;
    end else begin
      frame_err_q <= 1'b0;
      decode_q    <= 1'b0;
      if (fe)                  tcnt_q <= '0;
      else if (tcnt_q != TO_MAX) tcnt_q <= tcnt_q + 1'b1;
      case (st_q)
        S_IDLE: if (fe) begin
          if (!dat_s2_q) begin
            st_q     <= S_RECV;
            bitcnt_q <= '0;
          end else begin
            frame_err_q <= 1'b1;
          end
        end
        S_RECV: if (fe) begin
          if (bitcnt_q == 4'd8) begin
            par_q <= dat_s2_q;
            st_q  <= S_STOP;
          end else begin
            sr_q     <= {dat_s2_q, sr_q[7:1]};
            bitcnt_q <= bitcnt_q + 1'b1;
          end
        end else if (tcnt_q == TO_MAX) begin
          frame_err_q <= 1'b1;
          st_q        <= S_IDLE;
        end
        S_STOP: if (fe) begin
          st_q <= S_IDLE;
          if (dat_s2_q && (^{sr_q, par_q})) begin
            decode_q <= 1'b1;
            code_q   <= sr_q;
          end else begin
            frame_err_q <= 1'b1;
          end
        end else if (tcnt_q == TO_MAX) begin
          frame_err_q <= 1'b1;
          st_q        <= S_IDLE;
        end
        default: st_q <= S_IDLE;
      endcase
    end
  end

  assign frame_err = frame_err_q;
  assign is_ext    = (code_q == 8'hE0);
  assign is_rel    = (code_q == 8'hF0);
  assign dec_ev    = decode_q && !is_ext && !is_rel;
  assign ev        = {ext_q, rel_q, code_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext_q <= 1'b0;
      rel_q <= 1'b0;
    end else if (frame_err_q) begin
      ext_q <= 1'b0;
      rel_q <= 1'b0;
    end else if (decode_q) begin
      if (is_ext)      ext_q <= 1'b1;
      else if (is_rel) rel_q <= 1'b1;
      else begin
        ext_q <= 1'b0;
        rel_q <= 1'b0;
      end
    end
  end

`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [8:0] last_q;
  logic       last_vld_q;
  logic       hit;

  // Auto-repeat makes of the held key are swallowed; releases always pass
  assign hit      = last_vld_q && (last_q == {ext_q, code_q});
  assign push_req = dec_ev && !(!rel_q && hit);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q     <= '0;
      last_vld_q <= 1'b0;
    end else if (dec_ev) begin
      if (rel_q) begin
        if (hit) last_vld_q <= 1'b0;
      end else if (!hit) begin
        last_q     <= {ext_q, code_q};
        last_vld_q <= 1'b1;
      end
    end
  end
`else
  assign push_req = dec_ev;
`endif

  logic [DEPTH-1:0][9:0] mem_q;
  logic [AW:0]           wptr_q, rptr_q;
  logic                  empty, full, pop, do_push, overflow_q;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign pop     = !empty && ev_ready;
  assign do_push = push_req && (!full || pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      overflow_q <= push_req && full && !pop;
      if (do_push) begin
        mem_q[wptr_q[AW-1:0]] <= ev;
        wptr_q                <= wptr_q + 1'b1;
      end
      if (pop) rptr_q <= rptr_q + 1'b1;
    end
  end

  assign ev_valid = !empty;
  assign ev_data  = mem_q[rptr_q[AW-1:0]];
  assign overflow = overflow_q;
endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed + randomized bench for ps2_rx_fifo with a queue-based event model.
module tb_ps2_rx_fifo;
  localparam int FL = 8;
  localparam int TO = 200;
  localparam int D  = 8;
  localparam int H  = 20;

  logic       clk, reset_n, ps2_kbd_clk, ps2_kbd_data, ev_ready;
  logic [9:0] ev_data;
  logic       ev_valid, frame_err, overflow;

  ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO), .DEPTH(D)) dut (
    .clk(clk), .reset_n(reset_n), .ps2_kbd_clk(ps2_kbd_clk), .ps2_kbd_data(ps2_kbd_data),
    .ev_data(ev_data), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .frame_err(frame_err), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int err_cnt = 0, ovf_cnt = 0;
  int err_exp = 0, ovf_exp = 0;

  always @(posedge clk) begin
    if (frame_err === 1'b1) err_cnt++;
    if (overflow === 1'b1) ovf_cnt++;
  end

  // Reference: decoded events as a bounded queue, prefixes as two flags
  logic [9:0] q[$];
  bit         m_ext, m_rel, lm_vld;
  logic [8:0] lm;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_byte(input logic [7:0] b, input bit pop_same);
    bit keep;
    if (b == 8'hE0) m_ext = 1'b1;
    else if (b == 8'hF0) m_rel = 1'b1;
    else begin
      keep = 1'b1;
`ifdef PS2_TYPEMATIC_FILTER_EN
      if (!m_rel) begin
        if (lm_vld && lm == {m_ext, b}) keep = 1'b0;
        else begin lm = {m_ext, b}; lm_vld = 1'b1; end
      end else if (lm_vld && lm == {m_ext, b}) lm_vld = 1'b0;
`endif
      if (pop_same && q.size() > 0) void'(q.pop_front());
      if (keep) begin
        if (q.size() < D) q.push_back({m_ext, m_rel, b});
        else ovf_exp++;
      end
      m_ext = 1'b0;
      m_rel = 1'b0;
    end
  endfunction

  task automatic send_frame(input logic [7:0] code, input bit bad_par, input int nbits,
                            input bit lat_chk, input logic [9:0] lat_exp, input bit pop_push);
    logic [10:0] f;
    f = {1'b1, (~^code) ^ bad_par, code, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_kbd_data = f[i];
      repeat (H) @(negedge clk);
      ps2_kbd_clk = 1'b0;
      if (i == 10) begin
        // 2 sync + FILTER_LEN filter edges to the stop fe, then DECODE, then write
        for (int k = 1; k <= 11; k++) begin
          @(negedge clk);
          if (lat_chk && k == 10) check("lat_pre", ev_valid, 0);
          if (lat_chk && k == 11) begin
            check("lat_valid", ev_valid, 1);
            check("lat_data", ev_data, lat_exp);
          end
          if (pop_push && k == 10) ev_ready = 1'b1;
          if (pop_push && k == 11) ev_ready = 1'b0;
        end
        repeat (H - 11) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
      ps2_kbd_clk = 1'b1;
    end
    ps2_kbd_data = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 11, 1'b0, 10'h0, 1'b0);
    model_byte(b, 1'b0);
  endtask

  task automatic drain(input string tag);
    logic [9:0] e;
    @(negedge clk);
    ev_ready = 1'b1;
    while (q.size() > 0) begin
      e = q.pop_front();
      check({tag, "_valid"}, ev_valid, 1);
      check({tag, "_data"}, ev_data, e);
      @(negedge clk);
    end
    check({tag, "_empty"}, ev_valid, 0);
    ev_ready = 1'b0;
  endtask

  initial begin
    int n, kind;
    logic [7:0] c;
    reset_n = 1'b0; ev_ready = 1'b0;
    ps2_kbd_clk = 1'b1; ps2_kbd_data = 1'b1;
    m_ext = 0; m_rel = 0; lm_vld = 0; lm = '0;

    // Reset: line activity is ignored, outputs idle
    repeat (40) begin
      @(negedge clk);
      ps2_kbd_clk  = 1'($urandom_range(0, 1));
      ps2_kbd_data = 1'($urandom_range(0, 1));
    end
    check("rst_valid", ev_valid, 0);
    check("rst_data", ev_data, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_ovf", overflow, 0);
    ps2_kbd_clk = 1'b1; ps2_kbd_data = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    check("post_rst_err", err_cnt, 0);
    check("post_rst_valid", ev_valid, 0);

    // Clean 0x1C with latency check
    send_frame(8'h1C, 1'b0, 11, 1'b1, 10'h01C, 1'b0);
    model_byte(8'h1C, 1'b0);
    check("clean_err", err_cnt, 0);
    drain("clean");

    // Prefix folding then flags cleared
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75); send_byte(8'h16);
    drain("prefix");

    // Bad parity after a pending E0 prefix
    send_byte(8'hE0);
    send_frame(8'h1C, 1'b1, 11, 1'b0, 10'h0, 1'b0);
    err_exp++; m_ext = 0; m_rel = 0;
    check("par_err", err_cnt, err_exp);
    check("par_noev", ev_valid, 0);
    send_byte(8'h1C);
    drain("par_next");

    // Short glitches on an idle clock line
    for (int g = 0; g < 6; g++) begin
      n = $urandom_range(1, FL - 1);
      ps2_kbd_clk = 1'b0;
      repeat (n) @(negedge clk);
      ps2_kbd_clk = 1'b1;
      repeat (15) @(negedge clk);
    end
    check("glitch_err", err_cnt, err_exp);
    check("glitch_valid", ev_valid, 0);

    // Partial frame, clock stops, then timeout
    send_frame(8'h55, 1'b0, 5, 1'b0, 10'h0, 1'b0);
    repeat (TO + 10) @(negedge clk);
    err_exp++; m_ext = 0; m_rel = 0;
    check("timeout_err", err_cnt, err_exp);
    send_byte(8'h29);
    check("timeout_after_err", err_cnt, err_exp);
    drain("timeout_next");

    // Overflow: DEPTH+1 makes with no consumer
    for (int i = 0; i <= D; i++) send_byte(8'h30 + 8'(i));
    check("ovf_cnt", ovf_cnt, ovf_exp);
    check("ovf_valid", ev_valid, 1);
    // Push while full with a simultaneous pop
    send_frame(8'h40, 1'b0, 11, 1'b0, 10'h0, 1'b1);
    model_byte(8'h40, 1'b1);
    check("full_pushpop_ovf", ovf_cnt, ovf_exp);
    drain("full");

    // Repeated make (suppressed only with typematic filter)
    send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
    drain("repeat");

    // Randomized key streams
    for (int r = 0; r < 3; r++) begin
      n = $urandom_range(1, D + 2);
      for (int e = 0; e < n; e++) begin
        kind = $urandom_range(0, 3);
        c = 8'($urandom_range(1, 8'h7F));
        if (kind[1]) send_byte(8'hE0);
        if (kind[0]) send_byte(8'hF0);
        send_byte(c);
      end
      check("rand_ovf", ovf_cnt, ovf_exp);
      check("rand_err", err_cnt, err_exp);
      drain("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
